// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: data width, address encodings and
// controller state codes so the FSM and the register stage agree.
package router_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [1:0] ADDR_FIFO0   = 2'b00;
    localparam logic [1:0] ADDR_FIFO1   = 2'b01;
    localparam logic [1:0] ADDR_FIFO2   = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS     = 3'd0,
        ST_LOAD_FIRST_DATA    = 3'd1,
        ST_LOAD_DATA          = 3'd2,
        ST_FIFO_FULL          = 3'd3,
        ST_LOAD_AFTER_FULL    = 3'd4,
        ST_LOAD_PARITY        = 3'd5,
        ST_CHECK_PARITY_ERROR = 3'd6,
        ST_WAIT_TILL_EMPTY    = 3'd7
    } router_state_e;

    function automatic logic addr_is_valid(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity over header/payload, captured packet parity byte and the
// mismatch flag; only instantiated when ROUTER_PARITY_CHECK_EN is defined.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] acc_data,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  chk_en,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_parity <= '0;
            pkt_parity <= '0;
            err        <= 1'b0;
        end else if (clr) begin
            int_parity <= '0;
            pkt_parity <= '0;
            err        <= 1'b0;
        end else begin
            if (acc_en) int_parity <= int_parity ^ acc_data;
            if (cap_en) pkt_parity <= cap_data;
            if (chk_en) err        <= (int_parity != pkt_parity);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-state hold byte, parity
// tracking. Optional parity compare is built under ROUTER_PARITY_CHECK_EN.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    // pkt_valid is high for header and payload bytes and low on the parity
    // byte; fifo_full stalls the byte into hold_reg until laf_state replays it.
    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            header_reg <= '0;
        end else if (detect_add && pkt_valid && addr_is_valid(data_in[1:0])) begin
            header_reg <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout     <= '0;
            hold_reg <= '0;
        end else if (lfd_state) begin
            dout <= header_reg;
        end else if (ld_state) begin
            if (!fifo_full) dout     <= data_in;
            else            hold_reg <= data_in;
        end else if (laf_state) begin
            dout <= hold_reg;
        end else if (full_state) begin
            dout <= dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end
    end

    // A packet that ended during a stall gets parity_done once the held byte replays.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    logic                  acc_en;
    logic [DATA_WIDTH-1:0] acc_data;

    assign acc_en   = lfd_state || (ld_state && pkt_valid && !fifo_full);
    assign acc_data = lfd_state ? header_reg : data_in;

    router_parity_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .clk      (clk),
        .reset    (reset),
        .clr      (detect_add),
        .acc_en   (acc_en),
        .acc_data (acc_data),
        .cap_en   (ld_state && !pkt_valid && !fifo_full),
        .cap_data (data_in),
        .chk_en   (parity_done && rst_int_reg),
        .err      (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: reset, good/bad parity, full stall,
// low pkt_valid during stall, decode-priority corners and invalid address.
module tb_router_reg;
    import router_pkg::*;

`ifdef ROUTER_PARITY_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    router_reg u_dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: raw decode vector {detect_add, lfd, ld, laf, full, rst_int_reg}
    task automatic drive_raw(input logic [5:0] dec, input logic pv, input logic [7:0] d,
                             input logic full, input logic [7:0] exp_dout);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = dec;
        pkt_valid = pv;
        data_in   = d;
        fifo_full = full;
        exp_q.push_back(exp_dout);
        @(posedge clk);
        #1;
        check("dout", dout, exp_q.pop_front());
    endtask

    task automatic cyc(input router_state_e st, input logic pv, input logic [7:0] d,
                       input logic full, input logic [7:0] exp_dout);
        logic [5:0] dec;
        dec = {st == ST_DECODE_ADDRESS, st == ST_LOAD_FIRST_DATA, st == ST_LOAD_DATA,
               st == ST_LOAD_AFTER_FULL, st == ST_FIFO_FULL, st == ST_CHECK_PARITY_ERROR};
        drive_raw(dec, pv, d, full, exp_dout);
    endtask

    initial begin
        reset = 1'b1;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = '0;
        pkt_valid = 1'b0;
        data_in   = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_pd", parity_done, 1'b0);
        check("rst_low", low_pkt_valid, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;

        // reset asserted mid-payload, between clock edges
        cyc(ST_DECODE_ADDRESS, 1, 8'h0D, 0, 8'h00);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h11, 0, 8'h0D);
        cyc(ST_LOAD_DATA, 1, 8'h11, 0, 8'h11);
        cyc(ST_LOAD_DATA, 1, 8'h22, 0, 8'h22);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dout", dout, 8'h00);
        check("async_rst_pd", parity_done, 1'b0);
        check("async_rst_low", low_pkt_valid, 1'b0);
        check("async_rst_err", err, 1'b0);
        #1 reset = 1'b0;
        // zero parity byte straight after reset: compare proves int_parity is 0
        cyc(ST_LOAD_DATA, 0, 8'h00, 0, 8'h00);
        check("post_rst_pd", parity_done, 1'b1);
        cyc(ST_CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h00);
        check("post_rst_err", err, 1'b0);
        check("post_rst_low_clr", low_pkt_valid, 1'b0);

        // good packet 0D 11 22 33, parity 0D
        cyc(ST_DECODE_ADDRESS, 1, 8'h0D, 0, 8'h00);
        check("good_pd_clr", parity_done, 1'b0);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h11, 0, 8'h0D);
        cyc(ST_LOAD_DATA, 1, 8'h11, 0, 8'h11);
        cyc(ST_LOAD_DATA, 1, 8'h22, 0, 8'h22);
        cyc(ST_LOAD_DATA, 1, 8'h33, 0, 8'h33);
        cyc(ST_LOAD_DATA, 0, 8'h0D, 0, 8'h0D);
        check("good_pd", parity_done, 1'b1);
        check("good_low", low_pkt_valid, 1'b1);
        cyc(ST_LOAD_PARITY, 0, 8'h00, 0, 8'h0D);
        cyc(ST_CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h0D);
        check("good_err", err, 1'b0);
        check("good_low_clr", low_pkt_valid, 1'b0);
        check("good_pd_hold", parity_done, 1'b1);

        // bad parity: same packet, parity 0C
        cyc(ST_DECODE_ADDRESS, 1, 8'h0D, 0, 8'h0D);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h11, 0, 8'h0D);
        cyc(ST_LOAD_DATA, 1, 8'h11, 0, 8'h11);
        cyc(ST_LOAD_DATA, 1, 8'h22, 0, 8'h22);
        cyc(ST_LOAD_DATA, 1, 8'h33, 0, 8'h33);
        cyc(ST_LOAD_DATA, 0, 8'h0C, 0, 8'h0C);
        cyc(ST_CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h0C);
        check("bad_err", err, PCHK);
        cyc(ST_LOAD_PARITY, 0, 8'h00, 0, 8'h0C);
        check("bad_err_stable", err, PCHK);
        cyc(ST_DECODE_ADDRESS, 1, 8'h06, 0, 8'h0C);
        check("bad_err_clr", err, 1'b0);
        check("bad_pd_clr", parity_done, 1'b0);

        // full stall on payload byte 22; int parity 06^11^33 = 24
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h11, 0, 8'h06);
        cyc(ST_LOAD_DATA, 1, 8'h11, 0, 8'h11);
        cyc(ST_LOAD_DATA, 1, 8'h22, 1, 8'h11);
        cyc(ST_FIFO_FULL, 1, 8'h55, 1, 8'h11);
        cyc(ST_LOAD_AFTER_FULL, 1, 8'h33, 0, 8'h22);
        check("stall_pd", parity_done, 1'b0);
        cyc(ST_LOAD_DATA, 1, 8'h33, 0, 8'h33);
        cyc(ST_LOAD_DATA, 0, 8'h24, 0, 8'h24);
        check("stall_pd_set", parity_done, 1'b1);
        cyc(ST_CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'h24);
        check("stall_err", err, 1'b0);

        // pkt_valid drops while FIFO full
        cyc(ST_DECODE_ADDRESS, 1, 8'h0D, 0, 8'h24);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h11, 0, 8'h0D);
        cyc(ST_LOAD_DATA, 1, 8'h11, 0, 8'h11);
        cyc(ST_LOAD_DATA, 0, 8'hAA, 1, 8'h11);
        check("lowfull_low", low_pkt_valid, 1'b1);
        check("lowfull_pd0", parity_done, 1'b0);
        cyc(ST_FIFO_FULL, 0, 8'h00, 1, 8'h11);
        cyc(ST_LOAD_AFTER_FULL, 0, 8'h00, 0, 8'hAA);
        check("lowfull_pd1", parity_done, 1'b1);
        cyc(ST_CHECK_PARITY_ERROR, 0, 8'h00, 0, 8'hAA);
        check("lowfull_low_clr", low_pkt_valid, 1'b0);
        check("lowfull_err", err, PCHK);

        // low_pkt_valid: set beats rst_int_reg clear
        drive_raw(6'b001001, 0, 8'h77, 1, 8'hAA);
        check("low_set_wins", low_pkt_valid, 1'b1);
        // parity_done: detect_add clear beats ld set
        drive_raw(6'b101000, 0, 8'h05, 0, 8'h05);
        check("pd_clr_wins", parity_done, 1'b0);
        check("pd_clr_err", err, 1'b0);

        // header capture: valid, invalid address, then pkt_valid low
        cyc(ST_DECODE_ADDRESS, 1, 8'h02, 0, 8'h05);
        cyc(ST_DECODE_ADDRESS, 1, 8'h0F, 0, 8'h05);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h00, 0, 8'h02);
        check("inv_addr_err", err, 1'b0);
        cyc(ST_DECODE_ADDRESS, 0, 8'h01, 0, 8'h02);
        cyc(ST_LOAD_FIRST_DATA, 1, 8'h00, 0, 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
